// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai21_bist_pkg.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__oai21_bist_pkg
// Shared types and constants for the oai21 cell BIST controller.
//   state_t      : controller FSM states
//   NUM_VEC      : exhaustive vector count for a 3-input cell
//   FAIL_CNT_W   : width of the saturating mismatch counter
//   SETTLE_MIN/MAX : legal range of the SETTLE_CYC parameter
// ---------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu9t5v0__oai21_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam int NUM_VEC      = 8;
    localparam int VEC_W        = 3;
    localparam int FAIL_CNT_W   = 4;
    localparam int SETTLE_MIN   = 1;
    localparam int SETTLE_MAX   = 15;
    // Settle counter only needs to count up to SETTLE_MAX-1.
    localparam int SETTLE_W     = $clog2(SETTLE_MAX + 1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (v == {FAIL_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai21_bist_golden.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__oai21_bist_golden
// Combinational reference model of the oai21 cell: zn = ~((a1 | a2) & b).
//   a1, a2, b : stimulus currently applied to the cell under test
//   zn        : value the cell under test is expected to produce
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__oai21_bist_golden (
    input  logic a1,
    input  logic a2,
    input  logic b,
    output logic zn
);

    assign zn = ~((a1 | a2) & b);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai21_bist.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__oai21_bist
// Exhaustive BIST for one oai21 cell: drives all 8 input vectors, waits
// SETTLE_CYC cycles for each, samples ZN and compares it to the golden model.
//
// Parameter: SETTLE_CYC (1..15) cycles between driving a vector and sampling.
// Macro:     GF180MCU_FD_SC_MCU9T5V0__OAI21_BIST_LOOP_EN - when defined, START
//            seen in FIN restarts the run directly without passing via IDLE.
//
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous active-high reset
//   START     run request (sampled in IDLE only)
//   ZN        output of the cell under test
//   A1,A2,B   registered stimulus to the cell under test
//   BUSY      high while a run is in progress
//   DONE      one-cycle pulse at the end of a run
//   PASS      last completed run had no mismatches
//   FAIL_CNT  saturating mismatch count of the current/last run
//   FAIL_VEC  {A1,A2,B} of the first mismatching vector
//   state_dbg current controller state (debug observation)
//
// Handshake: START is a level request taken only when the controller is idle
// (BUSY low); the accepted run always ends with exactly one DONE pulse, at
// which point PASS/FAIL_CNT/FAIL_VEC are final. Reset aborts a run silently.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__oai21_bist
    import gf180mcu_fd_sc_mcu9t5v0__oai21_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ZN,
    output logic                  A1,
    output logic                  A2,
    output logic                  B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [FAIL_CNT_W-1:0] FAIL_CNT,
    output logic [VEC_W-1:0]      FAIL_VEC,
    output logic [2:0]            state_dbg
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0]    LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t              state;
    logic [VEC_W-1:0]    idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                zn_exp;

    gf180mcu_fd_sc_mcu9t5v0__oai21_bist_golden u_golden (
        .a1 (A1),
        .a2 (A2),
        .b  (B),
        .zn (zn_exp)
    );

    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            A1         <= 1'b0;
            A2         <= 1'b0;
            B          <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            FAIL_CNT   <= '0;
            FAIL_VEC   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Stimulus outputs deliberately keep the last vector here.
                    if (START) begin
                        state    <= ST_DRIVE;
                        idx      <= '0;
                        FAIL_CNT <= '0;
                        FAIL_VEC <= '0;
                        PASS     <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    {A1, A2, B} <= idx;
                    settle_cnt  <= '0;
                    state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (ZN != zn_exp) begin
                        FAIL_CNT <= sat_inc(FAIL_CNT);
                        // Only the first mismatch of a run is recorded.
                        if (FAIL_CNT == '0) begin
                            FAIL_VEC <= {A1, A2, B};
                        end
                    end
                    if (idx == LAST_VEC) begin
                        state <= ST_FIN;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                ST_FIN: begin
                    // FAIL_CNT already includes the last SAMPLE's result here.
                    DONE <= 1'b1;
                    PASS <= (FAIL_CNT == '0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI21_BIST_LOOP_EN
                    if (START) begin
                        state    <= ST_DRIVE;
                        idx      <= '0;
                        FAIL_CNT <= '0;
                        FAIL_VEC <= '0;
                    end else begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
`else
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
